// File: rtl/fp4_twiddle_gen_pkg.sv
// fp4_twiddle_gen_pkg
//   Shared definitions for the FP4 (E2M1, bias 1) twiddle generator:
//   FP4 codes, the round-to-nearest magnitude thresholds, the FSM state
//   type and a helper that applies a sign bit to a magnitude.
//   No ports (package).
package fp4_twiddle_gen_pkg;

  localparam logic [3:0] FP4_ZERO     = 4'b0000;
  localparam logic [3:0] FP4_HALF     = 4'b0001;
  localparam logic [3:0] FP4_ONE      = 4'b0010;
  localparam int         FP4_SIGN_BIT = 3;

  localparam logic [2:0] MAG_ZERO = FP4_ZERO[2:0];
  localparam logic [2:0] MAG_HALF = FP4_HALF[2:0];
  localparam logic [2:0] MAG_ONE  = FP4_ONE[2:0];

  // cos(x) thresholds scaled by TW_THR_SCALE: the points where the
  // quantised magnitude moves between 1.0 / 0.5 / 0 (0.75 and 0.25).
  localparam int unsigned TW_THR_ONE   = 32'd4601;
  localparam int unsigned TW_THR_HALF  = 32'd8391;
  localparam int unsigned TW_THR_SCALE = 32'd10000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Attach a sign to a magnitude; a zero magnitude always stays +0.
  function automatic logic [3:0] fp4_signed(input logic [2:0] mag, input logic neg);
    logic [3:0] res;
    if (mag == MAG_ZERO) begin
      res = FP4_ZERO;
    end else begin
      res = {neg, mag};
    end
    return res;
  endfunction

endpackage

// File: rtl/fp4_cos_mag.sv
// fp4_cos_mag
//   Combinational quantiser: returns |cos(2*pi*m/N)| rounded to the
//   nearest of {0, 0.5, 1.0} as a 3-bit E2M1 magnitude, for m in 0..N/4.
//   Ports:
//     m    in   N_LOG2-1  folded angle index (0..N/4)
//     mag  out  3         E2M1 magnitude {exp[1:0], man}
import fp4_twiddle_gen_pkg::*;

module fp4_cos_mag #(
  parameter int N_LOG2 = 3
) (
  input  logic [N_LOG2-2:0] m,
  output logic [2:0]        mag
);

  localparam int unsigned Q = 32'd1 << (N_LOG2 - 2);

  // Compare m/Q against the scaled cut points without any division.
  always_comb begin
    mag = MAG_ZERO;
    if ((32'(m) * TW_THR_SCALE) <= (TW_THR_ONE * Q)) begin
      mag = MAG_ONE;
    end else if ((32'(m) * TW_THR_SCALE) <= (TW_THR_HALF * Q)) begin
      mag = MAG_HALF;
    end else begin
      mag = MAG_ZERO;
    end
  end

endmodule

// File: rtl/fp4_twiddle_gen.sv
// fp4_twiddle_gen
//   Streams stage-ordered radix-2 DIT twiddles W_N^k in FP4 E2M1 over a
//   valid/ready handshake, one full FFT per start pulse.
//   Build option: define INVERSE_EN for conjugate (IFFT) twiddles.
//   Ports:
//     clk       in   1         clock, rising edge
//     rst       in   1         synchronous active-high reset
//     start     in   1         begin one stream (ignored while running)
//     tw_ready  in   1         consumer accepts current beat
//     tw_valid  out  1         beat valid
//     tw_re     out  4         FP4 cos term
//     tw_im     out  4         FP4 -sin term (+sin with INVERSE_EN)
//     tw_stage  out  3         stage s
//     tw_bfly   out  N_LOG2-1  butterfly index j
//     tw_last   out  1         final beat of the FFT
//     busy      out  1         stream in progress
//     done      out  1         one-cycle pulse after the last beat
import fp4_twiddle_gen_pkg::*;

module fp4_twiddle_gen #(
  parameter int N_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              tw_ready,
  output logic              tw_valid,
  output logic [3:0]        tw_re,
  output logic [3:0]        tw_im,
  output logic [2:0]        tw_stage,
  output logic [N_LOG2-2:0] tw_bfly,
  output logic              tw_last,
  output logic              busy,
  output logic              done
);

  localparam int              JW    = N_LOG2 - 1;
  localparam int unsigned     HALF  = 32'd1 << (N_LOG2 - 1);
  localparam int unsigned     Q     = 32'd1 << (N_LOG2 - 2);
  localparam logic [JW-1:0]   J_MAX = JW'(HALF - 32'd1);
  localparam logic [2:0]      S_MAX = 3'(N_LOG2 - 1);

`ifdef INVERSE_EN
  localparam logic IM_NEG = 1'b0;
`else
  localparam logic IM_NEG = 1'b1;
`endif

  state_t          state_r, state_s;
  logic [2:0]      s_r, s_s;
  logic [JW-1:0]   j_r, j_s;
  logic [JW-1:0]   k_s, cos_m_s, sin_m_s;
  logic            k_gt_q_s;
  logic [2:0]      cos_mag_s, sin_mag_s;
  logic            hs_s;
  logic            valid_s, last_s, done_s;
  logic [3:0]      re_s, im_s;

  assign hs_s = tw_valid & tw_ready;

  // FSM state and s/j counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      s_r     <= 3'd0;
      j_r     <= '0;
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      j_r     <= j_s;
    end
  end

  // Next state: start only matters in IDLE; the last handshake returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (hs_s && tw_last) state_s = ST_IDLE;
        else                 state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Advance (s, j) on each handshake; wrap to (0, 0) after the last beat.
  always_comb begin
    s_s = s_r;
    j_s = j_r;
    if (state_r == ST_RUN && hs_s) begin
      if (tw_last) begin
        s_s = 3'd0;
        j_s = '0;
      end else if (j_r == J_MAX) begin
        s_s = s_r + 3'd1;
        j_s = '0;
      end else begin
        j_s = j_r + JW'(1);
      end
    end else begin
      s_s = s_r;
      j_s = j_r;
    end
  end

  // Twiddle exponent and quadrant folding for the upcoming beat.
  // k = (j & (2^s-1)) << (N_LOG2-1-s); angles past Q are mirrored about N/4.
  always_comb begin
    k_s      = JW'((32'(j_s) & ((32'd1 << s_s) - 32'd1)) << (32'(N_LOG2 - 1) - 32'(s_s)));
    k_gt_q_s = (32'(k_s) > Q);
    if (k_gt_q_s) begin
      cos_m_s = JW'(HALF - 32'(k_s));
      sin_m_s = JW'(32'(k_s) - Q);
    end else begin
      cos_m_s = k_s;
      sin_m_s = JW'(Q - 32'(k_s));
    end
  end

  fp4_cos_mag #(.N_LOG2(N_LOG2)) u_cos_mag (
    .m   (cos_m_s),
    .mag (cos_mag_s)
  );

  fp4_cos_mag #(.N_LOG2(N_LOG2)) u_sin_mag (
    .m   (sin_m_s),
    .mag (sin_mag_s)
  );

  // Output values for the next cycle; data is zeroed whenever not streaming.
  always_comb begin
    valid_s = (state_s == ST_RUN);
    last_s  = valid_s && (s_s == S_MAX) && (j_s == J_MAX);
    done_s  = (state_r == ST_RUN) && hs_s && tw_last;
    if (valid_s) begin
      re_s = fp4_signed(cos_mag_s, k_gt_q_s);
      im_s = fp4_signed(sin_mag_s, IM_NEG);
    end else begin
      re_s = FP4_ZERO;
      im_s = FP4_ZERO;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tw_valid <= 1'b0;
      tw_re    <= FP4_ZERO;
      tw_im    <= FP4_ZERO;
      tw_stage <= 3'd0;
      tw_bfly  <= '0;
      tw_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tw_valid <= valid_s;
      tw_re    <= re_s;
      tw_im    <= im_s;
      tw_stage <= s_s;
      tw_bfly  <= j_s;
      tw_last  <= last_s;
      busy     <= valid_s;
      done     <= done_s;
    end
  end

endmodule
